// File: rtl/switches_to_led_pkg.sv
// Shared constants and helpers for the switch-to-LED debounce slice.
// Keeps parameter defaults and counter sizing in one place.
package switches_to_led_pkg;

   localparam int unsigned DEF_N               = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

   // Stability counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/switches_to_led_switch_debounce.sv
// One switch bit: two-flop synchroniser, stability counter, LED flop.
// The LED only moves after DEBOUNCE_CYCLES consecutive mismatches.
module switch_debounce
   import switches_to_led_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   output logic o_level
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;
   logic          r_level;

   logic          w_diff;
   logic          w_done;

   assign w_diff  = r_s2 ^ r_level;
   assign w_done  = (r_cnt == CNT_LAST);
   assign o_level = r_level;

   // Bring the asynchronous switch level into the clock domain.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_sw;
         r_s2 <= r_s1;
      end
   end

   // Count consecutive mismatches; clearing on agreement rejects glitches.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!w_diff || w_done) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Adopt the synchronised value once it has been stable long enough.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_level <= 1'b0;
      end else if (w_diff && w_done) begin
         r_level <= r_s2;
      end
   end

endmodule

// File: rtl/switches_to_led.sv
// Debounced, synchronised mapping of N slide switches onto N LEDs.
// Each bit has its own independent debounce channel.
module switches_to_led
   import switches_to_led_pkg::*;
#(
   parameter int unsigned N               = DEF_N,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_switch,
   output logic [N-1:0] o_led
);

   logic [N-1:0] w_led;

   assign o_led = w_led;

   // One channel per switch/LED pair.
   for (genvar k = 0; k < N; k++) begin : g_bit
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_sw   (i_switch[k]),
         .o_level(w_led[k])
      );
   end

endmodule

// File: tb/tb_switches_to_led.sv
// Self-checking bench for switches_to_led (N=4, DEBOUNCE_CYCLES=4).
// Directed scenarios plus random stimulus against a history-based model.
`timescale 1ns/1ps
module tb_switches_to_led;

   localparam int N  = 4;
   localparam int DC = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] sw;
   logic [N-1:0] led;

   int n_chk;
   int n_fail;

   // Model: samples taken at each edge, and per-bit mismatch run length.
   logic [N-1:0] samp_q[$];
   int           run[N];
   logic [N-1:0] m_led;

   switches_to_led #(
      .N(N),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_switch(sw),
      .o_led   (led)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] obs,
                        input logic [N-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // The value seen after synchronisation at an edge is the switch
   // level sampled two edges earlier (zero if reset intervened).
   task automatic model_edge(input logic [N-1:0] s, input logic r);
      logic [N-1:0] y;
      if (!r) begin
         samp_q = '{'0, '0};
         m_led  = '0;
         for (int k = 0; k < N; k++) run[k] = 0;
      end else begin
         y = samp_q[samp_q.size() - 2];
         for (int k = 0; k < N; k++) begin
            if (y[k] != m_led[k]) begin
               run[k] = run[k] + 1;
               if (run[k] == DC) begin
                  m_led[k] = y[k];
                  run[k]   = 0;
               end
            end else begin
               run[k] = 0;
            end
         end
         samp_q.push_back(s);
         if (samp_q.size() > 2) void'(samp_q.pop_front());
      end
   endtask

   task automatic step(input logic [N-1:0] s, input logic r);
      @(negedge clk);
      sw    = s;
      rst_n = r;
      @(posedge clk);
      model_edge(s, r);
      #1;
      check("model", led, m_led);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      sw     = '0;
      rst_n  = 1'b0;
      samp_q = '{'0, '0};
      m_led  = '0;
      for (int k = 0; k < N; k++) run[k] = 0;

      // 1: reset held with switches on, then release
      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 1'b0);
         check("reset_hold", led, 4'b0000);
      end
      for (int i = 1; i <= 6; i++) begin
         step(4'b1111, 1'b1);
         check("reset_release", led, (i < 6) ? 4'b0000 : 4'b1111);
      end

      // 2: return to idle, then a single-bit change
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      check("idle", led, 4'b0000);
      for (int i = 1; i <= 6; i++) begin
         step(4'b0100, 1'b1);
         check("single", led, (i < 6) ? 4'b0000 : 4'b0100);
      end
      for (int i = 0; i < 4; i++) step(4'b0100, 1'b1);

      // 3: multi-bit changes all land on the same edge
      begin
         logic [N-1:0] pats[3];
         logic [N-1:0] prev;
         pats = '{4'b1010, 4'b0101, 4'b1010};
         prev = 4'b0100;
         for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= 10; i++) begin
               step(pats[p], 1'b1);
               if (i == 5) check("multi_before", led, prev);
               if (i == 6) check("multi_after", led, pats[p]);
            end
            prev = pats[p];
         end
      end

      // 4: short glitch rejected, longer pulse passed
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         step((i <= 3) ? 4'b0001 : 4'b0000, 1'b1);
         check("glitch3", led, 4'b0000);
      end
      for (int i = 1; i <= 16; i++) begin
         step((i <= 6) ? 4'b0001 : 4'b0000, 1'b1);
         check("pulse6", led,
               (i >= 6 && i <= 11) ? 4'b0001 : 4'b0000);
      end

      // 5: reset in the middle of a count
      for (int i = 1; i <= 3; i++) step(4'b0011, 1'b1);
      step(4'b0011, 1'b0);
      check("midreset", led, 4'b0000);
      for (int i = 1; i <= 6; i++) begin
         step(4'b0011, 1'b1);
         check("midreset_rel", led, (i < 6) ? 4'b0000 : 4'b0011);
      end

      // 6: bounce on bit 3, then stable high
      for (int j = 1; j <= 10; j++) begin
         step((j % 2 == 1) ? 4'b1011 : 4'b0011, 1'b1);
         check("bounce", led, 4'b0011);
      end
      for (int i = 1; i <= 6; i++) begin
         step(4'b1011, 1'b1);
         check("bounce_settle", led, (i < 6) ? 4'b0011 : 4'b1011);
      end

      // Random segments against the model, with occasional reset
      for (int seg = 0; seg < 120; seg++) begin
         logic [N-1:0] v;
         int           hold;
         logic         r;
         v    = N'($urandom_range(0, (1 << N) - 1));
         hold = $urandom_range(1, 8);
         r    = ($urandom_range(0, 19) != 0);
         for (int i = 0; i < hold; i++) step(v, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
